// File: rtl/alsu_pkg.sv
// Shared opcode/state encodings and width helper for the sequential ALSU.
package alsu_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_XOR    = 3'd1,
        OP_ADD    = 3'd2,
        OP_MUL    = 3'd3,
        OP_SHIFT  = 3'd4,
        OP_ROTATE = 3'd5,
        OP_INV6   = 3'd6,
        OP_INV7   = 3'd7
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_e;

    function automatic int out_w(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/alsu_seq_mult.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles.
module alsu_seq_mult
    import alsu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    output logic                      done,
    output logic [out_w(WIDTH)-1:0]   prod
);

    localparam int OUT_W = out_w(WIDTH);
    localparam int CW    = $clog2(WIDTH);

    logic             run_q, run_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [OUT_W-1:0] mcand_q, mcand_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [OUT_W-1:0] sum;

    // prod is the accumulator including the current partial product,
    // so it is final in the cycle done is high.
    always_comb begin
        sum      = acc_q + (mplier_q[0] ? mcand_q : '0);
        done     = run_q && (cnt_q == CW'(WIDTH - 1));
        prod     = sum;
        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
        if (start) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = OUT_W'(a);
            mplier_d = b;
        end else if (run_q) begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (done) run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
        end
    end

endmodule

// File: rtl/alsu_seq.sv
// Sequential ALSU: single-cycle logic/add/shift ops plus a multi-cycle
// multiply, with a valid/ready request port and an error LED bank.
module alsu_seq
    import alsu_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter     INPUT_PRIORITY = "A",
    parameter     FULL_ADDER     = "ON",
    parameter int LED_W          = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH-1:0]        a,
    input  logic [WIDTH-1:0]        b,
    input  logic [2:0]              opcode,
    input  logic                    cin,
    input  logic                    serialin,
    input  logic                    direction,
    input  logic                    red_op_a,
    input  logic                    red_op_b,
    input  logic                    bypass_a,
    input  logic                    bypass_b,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [out_w(WIDTH)-1:0] out,
    output logic                    out_valid,
    output logic [LED_W-1:0]        leds,
    output logic                    busy
);

    localparam int OUT_W = out_w(WIDTH);
    localparam bit PRI_A = (INPUT_PRIORITY == "A");
    localparam bit FA_ON = (FULL_ADDER == "ON");

    state_e           state_q, state_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic             valid_q, valid_d;
    logic [LED_W-1:0] leds_q, leds_d;

    logic             accept, start, done;
    logic             byp, red_any, bad;
    logic [WIDTH-1:0] byp_op, red_op;
    logic [WIDTH:0]   sum;
    logic [OUT_W-1:0] prod;
    opcode_e          op;

    alsu_seq_mult #(.WIDTH(WIDTH)) u_mult (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .done  (done),
        .prod  (prod)
    );

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == MUL);
    assign out       = out_q;
    assign out_valid = valid_q;
    assign leds      = leds_q;

    always_comb begin
        op      = opcode_e'(opcode);
        accept  = in_valid && in_ready;
        byp     = bypass_a || bypass_b;
        byp_op  = (bypass_a && (!bypass_b || PRI_A)) ? a : b;
        red_any = red_op_a || red_op_b;
        red_op  = (red_op_a && (!red_op_b || PRI_A)) ? a : b;
        bad     = !byp && ((red_any && (opcode >= 3'd2))
                           || (opcode >= 3'd6));
        sum     = {1'b0, a} + {1'b0, b}
                + {{WIDTH{1'b0}}, cin & FA_ON};
        state_d = state_q;
        out_d   = out_q;
        valid_d = 1'b0;
        leds_d  = leds_q;
        start   = 1'b0;
        if (state_q == MUL) begin
            if (done) begin
                out_d   = prod;
                valid_d = 1'b1;
                state_d = IDLE;
            end
        end else if (accept) begin
            valid_d = 1'b1;
            unique case (1'b1)
                byp: out_d = OUT_W'(byp_op);
                bad: begin
                    out_d  = '0;
                    leds_d = ~leds_q;
                end
                default: begin
                    case (op)
                        OP_AND: out_d = red_any ? OUT_W'(&red_op)
                                                : OUT_W'(a & b);
                        OP_XOR: out_d = red_any ? OUT_W'(^red_op)
                                                : OUT_W'(a ^ b);
                        OP_ADD: out_d = OUT_W'(sum);
                        OP_MUL: begin
                            // result register holds until the product lands
                            valid_d = 1'b0;
                            start   = 1'b1;
                            state_d = MUL;
                        end
                        OP_SHIFT: out_d = direction
                            ? {out_q[OUT_W-2:0], serialin}
                            : {serialin, out_q[OUT_W-1:1]};
                        OP_ROTATE: out_d = direction
                            ? {out_q[OUT_W-2:0], out_q[OUT_W-1]}
                            : {out_q[0], out_q[OUT_W-1:1]};
                        default: out_d = out_q;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            valid_q <= 1'b0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            leds_q  <= leds_d;
        end
    end

endmodule

// File: tb/tb_alsu_seq.sv
// Self-checking bench for alsu_seq (WIDTH=4, default parameters).
module tb_alsu_seq;

    localparam int W  = 4;
    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  a, b;
    logic [2:0]    opcode;
    logic          cin, serialin, direction;
    logic          red_op_a, red_op_b, bypass_a, bypass_b;
    logic          in_valid;
    logic          in_ready;
    logic [OW-1:0] out;
    logic          out_valid;
    logic [15:0]   leds;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    logic [7:0]    m_out;
    logic [15:0]   m_leds;

    always #5 clk = ~clk;

    alsu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .cin       (cin),
        .serialin  (serialin),
        .direction (direction),
        .red_op_a  (red_op_a),
        .red_op_b  (red_op_b),
        .bypass_a  (bypass_a),
        .bypass_b  (bypass_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (out),
        .out_valid (out_valid),
        .leds      (leds),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input logic [3:0] ta, tb, input logic [2:0] op,
                         input logic c, si, d, ra, rb, ba, bb, iv);
        a = ta; b = tb; opcode = op; cin = c; serialin = si;
        direction = d; red_op_a = ra; red_op_b = rb;
        bypass_a = ba; bypass_b = bb; in_valid = iv;
    endtask

    // Reference: result of one single-cycle request from the rules
    task automatic single(input logic [3:0] ta, tb, input logic [2:0] op,
                          input logic c, si, d, ra, rb, ba, bb);
        logic [7:0] e;
        logic [3:0] x;
        e = m_out;
        x = ra ? ta : tb;
        if (ba || bb) e = ba ? 8'(ta) : 8'(tb);
        else if (op >= 6 || ((ra || rb) && op >= 2)) begin
            e = 0;
            m_leds = ~m_leds;
        end else begin
            case (op)
                0: e = (ra || rb) ? ((x == 4'hF) ? 8'd1 : 8'd0)
                                  : 8'(ta & tb);
                1: e = (ra || rb) ? 8'($countones(x) % 2) : 8'(ta ^ tb);
                2: e = 8'(ta + tb + c);
                4: e = d ? 8'((m_out * 2 + si) % 256)
                         : 8'(m_out / 2 + si * 128);
                5: e = d ? 8'((m_out * 2) % 256 + m_out / 128)
                         : 8'(m_out / 2 + (m_out % 2) * 128);
                default: e = m_out;
            endcase
        end
        m_out = e;
        drive(ta, tb, op, c, si, d, ra, rb, ba, bb, 1'b1);
        check("ready_pre", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("out", out, m_out);
        check("out_valid", out_valid, 1);
        check("leds", leds, m_leds);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("idle_valid", out_valid, 0);
        check("idle_out", out, m_out);
    endtask

    task automatic mul(input logic [3:0] ta, tb, input logic disturb);
        logic [7:0] p;
        p = 8'(ta * tb);
        drive(ta, tb, 3'd3, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < W; k++) begin
            check("mul_ready", in_ready, 0);
            check("mul_busy", busy, 1);
            check("mul_valid", out_valid, 0);
            check("mul_hold", out, m_out);
            drive(4'($urandom), 4'($urandom), 3'($urandom_range(0, 2)),
                  0, 0, 0, 0, 0, 0, 0, disturb);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        m_out = p;
        check("mul_out", out, m_out);
        check("mul_done_valid", out_valid, 1);
        check("mul_done_ready", in_ready, 1);
        check("mul_done_busy", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic [3:0] ra4, rb4;
        logic [2:0] rop;
        logic       fra, frb, fba, fbb;
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        m_out = 0;
        m_leds = 0;
        #12;
        check("rst_out", out, 0);
        check("rst_leds", leds, 0);
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        check("rst_ready", in_ready, 1);

        single(5, 3, 2, 1, 0, 0, 0, 0, 0, 0);
        idle();
        mul(15, 15, 1'b1);
        idle();
        // accepted in the completion cycle of a multiply
        mul(6, 7, 1'b0);
        single(3, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        single(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        check("rot_r", out, 8'h81);
        single(0, 0, 5, 0, 0, 1, 0, 0, 0, 0);
        check("rot_l", out, 8'h03);
        single(0, 0, 4, 0, 1, 0, 0, 0, 0, 0);
        check("shr", out, 8'h81);
        single(1, 2, 6, 0, 0, 0, 0, 0, 0, 0);
        check("inv1_leds", leds, 16'hFFFF);
        single(1, 2, 6, 0, 0, 0, 0, 0, 0, 0);
        check("inv2_leds", leds, 16'h0000);
        single(4, 4, 2, 0, 0, 0, 1, 0, 0, 0);
        single(2, 7, 1, 0, 0, 0, 0, 0, 1, 1);
        check("byp_both", out, 2);
        idle();

        // reset in the middle of a multiply
        drive(9, 9, 3'd3, 0, 0, 0, 0, 0, 0, 0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        m_out = 0;
        m_leds = 0;
        check("mrst_out", out, 0);
        check("mrst_valid", out_valid, 0);
        check("mrst_busy", busy, 0);
        @(negedge clk) rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            check("mrst_novalid", out_valid, 0);
            check("mrst_ready", in_ready, 1);
            check("mrst_outz", out, 0);
        end

        for (int i = 0; i < 80; i++) begin
            ra4 = 4'($urandom);
            rb4 = 4'($urandom);
            rop = 3'($urandom);
            fra = ($urandom_range(0, 5) == 0);
            frb = ($urandom_range(0, 5) == 0);
            fba = ($urandom_range(0, 7) == 0);
            fbb = ($urandom_range(0, 7) == 0);
            if (rop == 3 && !(fra || frb || fba || fbb))
                mul(ra4, rb4, 1'($urandom));
            else
                single(ra4, rb4, rop, 1'($urandom), 1'($urandom),
                       1'($urandom), fra, frb, fba, fbb);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
